// File: rtl/logic_gates_seq.sv
// logic_gates_seq: registered bitwise gate unit with a debounced mode button.
// Operands and the button arrive from asynchronous board pins. Each one is
// synchronised, the button is debounced, and every button release steps
// through eight bitwise functions.
module logic_gates_seq #(
  parameter int unsigned WIDTH          = 2,
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Mode_Btn,
  output logic [WIDTH-1:0] o_Result,
  output logic [2:0]       o_Mode,
  output logic             o_Mode_Strobe
);

  localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NOTA = 3'd3,
    MODE_NAND = 3'd4,
    MODE_NOR  = 3'd5,
    MODE_XNOR = 3'd6,
    MODE_PASS = 3'd7
  } mode_e;

  logic [WIDTH-1:0] a_s1, a_s2;
  logic [WIDTH-1:0] b_s1, b_s2;
  logic             btn_s1, btn_s2;
  logic             btn_stable;
  logic [CNT_W-1:0] db_cnt;
  logic             release_evt;
  mode_e            mode_q, mode_d;
  logic             strobe_q, strobe_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Two-flop synchronisers for the asynchronous pins
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      a_s1   <= '0;
      a_s2   <= '0;
      b_s1   <= '0;
      b_s2   <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      a_s1   <= i_A;
      a_s2   <= a_s1;
      b_s1   <= i_B;
      b_s2   <= b_s1;
      btn_s1 <= i_Mode_Btn;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_LIMIT consecutive mismatches
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      btn_stable <= 1'b0;
      db_cnt     <= '0;
    end else if (btn_s2 == btn_stable) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_MAX) begin
      btn_stable <= btn_s2;
      db_cnt     <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // A release is the edge on which the stable level falls from 1 to 0
  assign release_evt = btn_stable && !btn_s2 && (db_cnt == CNT_MAX);

  // Mode FSM state register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_q   <= MODE_AND;
      strobe_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      strobe_q <= strobe_d;
    end
  end

  // Mode FSM next state: advance (with wrap) once per release
  always_comb begin
    mode_d   = mode_q;
    strobe_d = 1'b0;
    if (release_evt) begin
      mode_d   = mode_e'(mode_q + 3'd1);
      strobe_d = 1'b1;
    end
  end

  // Gate function for the current mode on synchronised operands
  always_comb begin
    result_d = '0;
    case (mode_q)
      MODE_AND:  result_d = a_s2 & b_s2;
      MODE_OR:   result_d = a_s2 | b_s2;
      MODE_XOR:  result_d = a_s2 ^ b_s2;
      MODE_NOTA: result_d = ~a_s2;
      MODE_NAND: result_d = ~(a_s2 & b_s2);
      MODE_NOR:  result_d = ~(a_s2 | b_s2);
      MODE_XNOR: result_d = ~(a_s2 ^ b_s2);
      MODE_PASS: result_d = a_s2;
      default:   result_d = '0;
    endcase
  end

  // Result register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign o_Result      = result_q;
  assign o_Mode        = mode_q;
  assign o_Mode_Strobe = strobe_q;

endmodule

// File: tb/tb_logic_gates_seq.sv
// Bench for logic_gates_seq: directed scenarios plus random stimulus checked
// every cycle against a cycle-level behavioural model.
module tb_logic_gates_seq;

  localparam int unsigned W   = 4;
  localparam int unsigned LIM = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         btn;
  logic [W-1:0] o_result;
  logic [2:0]   o_mode;
  logic         o_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  logic_gates_seq #(.WIDTH(W), .DEBOUNCE_LIMIT(LIM)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_A(a), .i_B(b), .i_Mode_Btn(btn),
    .o_Result(o_result), .o_Mode(o_mode), .o_Mode_Strobe(o_strobe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gate(input logic [2:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    case (m)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~x;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // Behavioural model: inputs seen two edges late; the stable button level
  // flips when the last LIM delayed samples all disagree with it.
  logic [W-1:0] a_hist[$], b_hist[$];
  logic         btn_hist[$];
  logic         win[$];
  logic         m_s;
  logic [2:0]   m_mode;
  logic [W-1:0] m_res;
  logic         m_strobe;
  logic [W-1:0] m_a2, m_b2;
  logic         m_bt2, m_flip;

  task automatic model_reset();
    a_hist.delete(); b_hist.delete(); btn_hist.delete(); win.delete();
    repeat (2) begin
      a_hist.push_back('0); b_hist.push_back('0); btn_hist.push_back(1'b0);
    end
    m_s = 1'b0; m_mode = 3'd0; m_res = '0; m_strobe = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_a2  = a_hist[0];
      m_b2  = b_hist[0];
      m_bt2 = btn_hist[0];
      a_hist.push_back(a);     void'(a_hist.pop_front());
      b_hist.push_back(b);     void'(b_hist.pop_front());
      btn_hist.push_back(btn); void'(btn_hist.pop_front());
      win.push_back(m_bt2);
      if (win.size() > LIM) void'(win.pop_front());
      m_flip = (win.size() == LIM);
      foreach (win[i]) if (win[i] == m_s) m_flip = 1'b0;
      m_res    = gate(m_mode, m_a2, m_b2);
      m_strobe = 1'b0;
      if (m_flip) begin
        if (m_s) begin
          m_mode   = m_mode + 3'd1;
          m_strobe = 1'b1;
        end
        m_s = ~m_s;
        win.delete();
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_result", 32'(o_result), 32'(m_res));
      chk("model_mode",   32'(o_mode),   32'(m_mode));
      chk("model_strobe", 32'(o_strobe), 32'(m_strobe));
    end
    if (o_strobe === 1'b1) strobe_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int rel);
    btn = 1'b1; cyc(hold);
    btn = 1'b0; cyc(rel);
  endtask

  logic [W-1:0] tab[8];
  logic [W-1:0] ad[40], bd[40];
  int s0, first, cnt, hold;

  initial begin
    rst = 1'b1; a = 4'b1100; b = 4'b1010; btn = 1'b0;
    tab = '{4'b1110, 4'b0110, 4'b0011, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b1000};
    cyc(3);
    rst = 1'b0;

    // 1: reset values and three-edge operand latency
    cyc(1); chk("lat_e1_result", 32'(o_result), 32'(4'b0000));
    chk("lat_e1_mode", 32'(o_mode), 32'd0);
    cyc(1); chk("lat_e2_result", 32'(o_result), 32'(4'b0000));
    cyc(1); chk("lat_e3_result", 32'(o_result), 32'(4'b1000));

    // 2: eight clean press/release cycles walk every mode
    s0 = strobe_cnt;
    for (int i = 0; i < 8; i++) begin
      press(10, 10);
      chk("step_mode", 32'(o_mode), 32'((i + 1) % 8));
      chk("step_result", 32'(o_result), 32'(tab[i]));
    end
    chk("step_strobes", 32'(strobe_cnt - s0), 32'd8);

    // 3: bounce shorter than the debounce window is ignored
    s0 = strobe_cnt;
    for (int i = 0; i < 40; i++) begin
      btn = (i % 6 == 0) || (i % 6 >= 2 && i % 6 <= 4);
      cyc(1);
    end
    btn = 1'b0; cyc(8);
    chk("bounce_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("bounce_mode", 32'(o_mode), 32'd0);

    // 4: long hold, one strobe shortly after release
    s0 = strobe_cnt;
    btn = 1'b1; cyc(100);
    chk("hold_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("hold_mode", 32'(o_mode), 32'd0);
    btn = 1'b0; first = 0; cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (o_strobe === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("rel_strobe_count", 32'(cnt), 32'd1);
    chk("rel_strobe_window", 32'(first >= int'(LIM) + 2 && first <= int'(LIM) + 3), 32'd1);
    chk("rel_mode", 32'(o_mode), 32'd1);

    // 5: reset while in mode 5 with the button held
    repeat (4) press(10, 10);
    chk("pre_rst_mode", 32'(o_mode), 32'd5);
    btn = 1'b1; cyc(8);
    #2 rst = 1'b1;
    #1 chk("async_rst_mode", 32'(o_mode), 32'd0);
    chk("async_rst_result", 32'(o_result), 32'd0);
    chk("async_rst_strobe", 32'(o_strobe), 32'd0);
    cyc(3);
    rst = 1'b0;
    s0 = strobe_cnt;
    cyc(2); btn = 1'b0; cyc(15);
    chk("short_hold_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("short_hold_mode", 32'(o_mode), 32'd0);
    press(10, 10);
    chk("post_rst_mode", 32'(o_mode), 32'd1);

    // 6: XOR mode with B toggling every cycle
    press(10, 10);
    chk("xor_mode", 32'(o_mode), 32'd2);
    for (int j = 0; j < 40; j++) begin
      ad[j] = (j % 5 == 0) ? W'($urandom) : a;
      bd[j] = ~b;
      if (j >= 3) chk("xor_pipe", 32'(o_result), 32'(ad[j-3] ^ bd[j-3]));
      a = ad[j]; b = bd[j];
      cyc(1);
    end

    // Random operands, button activity and occasional resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn  = ~btn;
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      if ($urandom_range(0, 2) == 0) a = W'($urandom);
      if ($urandom_range(0, 2) == 0) b = W'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rand_rst_mode", 32'(o_mode), 32'd0);
        cyc(2);
        rst = 1'b0;
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
